instr_decode_stage: RTL

Registered RV32I instruction decode stage for the unicycle core. It sits between instruction fetch and register-file/ALU issue, and exchanges data with both neighbours over valid/ready handshakes. It consumes a raw 32-bit instruction word plus its PC. One cycle later it presents the decoded fields, a sign-extended immediate and control strobes, drawing ALU operation codes and opcode values from the `defines` package. It flags encodings the datapath cannot execute and counts them.

---
 rtl/defines.sv | 95 +++++++++
 rtl/instr_decode_stage_decoder.sv | 135 +++++++++++++
 rtl/instr_decode_stage.sv | 55 +++++
 3 files changed

// File: rtl/defines.sv
// Shared RV32I encodings, ALU operation codes and decode-stage bundle types.
package defines;

    localparam int unsigned XLEN = 32;

    // Major opcodes handled by the datapath
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;

    // AND is encoding 0 so an all-zero bundle reads as a benign ALU op
    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3
    } aluOperations_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_format_t;

    typedef struct packed {
        logic       imm12;
        logic [5:0] imm10_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [3:0] imm4_1;
        logic       imm11;
        logic [6:0] opcode;
    } instruction_btype_t;

    typedef struct packed {
        logic       imm20;
        logic [9:0] imm10_1;
        logic       imm11;
        logic [7:0] imm19_12;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_jtype_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        aluOperations_t  aluOp;
        logic            aluSrcImm;
        logic            aluSrcPc;
        logic            regWrite;
        logic            memRead;
        logic            memWrite;
        logic            branch;
        logic            jump;
        logic            illegal;
    } decoded_t;

    // Sign-extended immediate for the given instruction format
    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr,
                                                input imm_format_t fmt);
        instruction_btype_t b;
        instruction_jtype_t j;
        logic [XLEN-1:0]    imm;
        b   = instruction_btype_t'(instr);
        j   = instruction_jtype_t'(instr);
        imm = '0;
        case (fmt)
            IMM_I:   imm = XLEN'($signed(instr[31:20]));
            IMM_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:   imm = XLEN'($signed({b.imm12, b.imm11, b.imm10_5, b.imm4_1, 1'b0}));
            IMM_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_J:   imm = XLEN'($signed({j.imm20, j.imm19_12, j.imm11, j.imm10_1, 1'b0}));
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/instr_decode_stage_decoder.sv
// Combinational RV32I decoder: raw instruction word and PC to decoded_t.
module instr_decoder
    import defines::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output decoded_t        dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    imm_format_t fmt;
    logic        legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Field extraction, control strobes and legality per opcode
    always_comb begin
        dec        = '0;
        dec.pc     = pc;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = funct3;
        fmt        = IMM_NONE;
        legal      = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.regWrite = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == FUNCT7_ZERO) begin
                            dec.aluOp = ALU_ADD;
                            legal     = 1'b1;
                        end else if (funct7 == FUNCT7_SUB) begin
                            dec.aluOp = ALU_SUB;
                            legal     = 1'b1;
                        end
                    end
                    3'b111: begin
                        dec.aluOp = ALU_AND;
                        legal     = (funct7 == FUNCT7_ZERO);
                    end
                    3'b110: begin
                        dec.aluOp = ALU_OR;
                        legal     = (funct7 == FUNCT7_ZERO);
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                fmt           = IMM_I;
                dec.aluSrcImm = 1'b1;
                dec.regWrite  = 1'b1;
                case (funct3)
                    3'b000:  begin dec.aluOp = ALU_ADD; legal = 1'b1; end
                    3'b111:  begin dec.aluOp = ALU_AND; legal = 1'b1; end
                    3'b110:  begin dec.aluOp = ALU_OR;  legal = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                fmt           = IMM_I;
                dec.aluOp     = ALU_ADD;
                dec.aluSrcImm = 1'b1;
                dec.memRead   = 1'b1;
                dec.regWrite  = 1'b1;
                legal         = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OPC_STORE: begin
                fmt           = IMM_S;
                dec.aluOp     = ALU_ADD;
                dec.aluSrcImm = 1'b1;
                dec.memWrite  = 1'b1;
                legal         = (funct3 inside {3'b000, 3'b001, 3'b010});
            end
            OPC_BRANCH: begin
                fmt        = IMM_B;
                dec.aluOp  = ALU_SUB;
                dec.branch = 1'b1;
                legal      = !(funct3 inside {3'b010, 3'b011});
            end
            OPC_JAL: begin
                fmt          = IMM_J;
                dec.aluOp    = ALU_ADD;
                dec.aluSrcPc = 1'b1;
                dec.jump     = 1'b1;
                dec.regWrite = 1'b1;
                legal        = 1'b1;
            end
            OPC_JALR: begin
                fmt           = IMM_I;
                dec.aluOp     = ALU_ADD;
                dec.aluSrcImm = 1'b1;
                dec.jump      = 1'b1;
                dec.regWrite  = 1'b1;
                legal         = (funct3 == 3'b000);
            end
            OPC_LUI: begin
                fmt           = IMM_U;
                dec.rs1       = '0;
                dec.aluOp     = ALU_ADD;
                dec.aluSrcImm = 1'b1;
                dec.regWrite  = 1'b1;
                legal         = 1'b1;
            end
            OPC_AUIPC: begin
                fmt           = IMM_U;
                dec.aluOp     = ALU_ADD;
                dec.aluSrcPc  = 1'b1;
                dec.aluSrcImm = 1'b1;
                dec.regWrite  = 1'b1;
                legal         = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        dec.imm = gen_imm(instr, fmt);
        // Illegal encodings keep their raw fields but must not cause any side effect
        if (!legal) begin
            dec.aluOp     = ALU_AND;
            dec.aluSrcImm = 1'b0;
            dec.aluSrcPc  = 1'b0;
            dec.regWrite  = 1'b0;
            dec.memRead   = 1'b0;
            dec.memWrite  = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
            dec.illegal   = 1'b1;
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: valid/ready pipeline register around instr_decoder
// plus a saturating count of illegal instructions handed downstream.
module instr_decode_stage
    import defines::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output decoded_t         out_dec,
    output logic [CNT_W-1:0] illegal_count
);

    decoded_t next_dec;

    instr_decoder u_decoder (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (next_dec)
    );

    assign in_ready = !out_valid || out_ready;

    // Pipeline register: flush beats capture, capture beats drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_dec   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_dec   <= next_dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Count illegal bundles on the output handshake, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_count <= '0;
        end else if (out_valid && out_ready && out_dec.illegal && (illegal_count != '1)) begin
            illegal_count <= illegal_count + CNT_W'(1);
        end
    end

endmodule
